// File: rtl/decodificador_cuadratura.sv
// Quadrature encoder front end: sync, debounce, Gray decode into up/down/err strobes.
// Define DECODIFICADOR_X4_EN for x4 resolution (one strobe per step instead of per detent).
module decodificador_cuadratura #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic a,
    input  logic b,
    output logic up,
    output logic down,
    output logic err,
    output logic dir
);

    typedef enum logic [0:0] {StInit, StTrack} state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q;
    logic [1:0]       sync1_q, s_ab_q, filt_q, old_q;
    logic [CNT_W-1:0] cnt_q, init_q;
    logic             ev_q;
    logic             cw_q, ccw_q, jump_q;
    logic             differ, accept;
    logic [1:0]       delta;

    // Map Gray code to its position on the CW circle: 00,01,11,10 -> 0,1,2,3.
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    always_comb begin
        differ = (s_ab_q != filt_q);
        accept = differ && (cnt_q == CntMax);
        delta  = gray_pos(filt_q) - gray_pos(old_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b00;
            s_ab_q  <= 2'b00;
            filt_q  <= 2'b00;
            old_q   <= 2'b00;
            cnt_q   <= '0;
            init_q  <= '0;
            state_q <= StInit;
            ev_q    <= 1'b0;
        end else begin
            sync1_q <= {a, b};
            s_ab_q  <= sync1_q;
            ev_q    <= 1'b0;
            if (!differ) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q  <= '0;
                filt_q <= s_ab_q;
                old_q  <= filt_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            case (state_q)
                StInit: begin
                    // First accepted value only seeds filt_ab; a quiet 00 start also arms tracking.
                    if (accept) begin
                        state_q <= StTrack;
                    end else if (s_ab_q == 2'b00) begin
                        if (init_q == CntMax) state_q <= StTrack;
                        else                  init_q  <= init_q + 1'b1;
                    end else begin
                        init_q <= '0;
                    end
                end
                StTrack: begin
                    if (accept) ev_q <= 1'b1;
                end
                default: state_q <= StInit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cw_q   <= 1'b0;
            ccw_q  <= 1'b0;
            jump_q <= 1'b0;
        end else begin
            cw_q   <= ev_q && (delta == 2'd1);
            ccw_q  <= ev_q && (delta == 2'd3);
            jump_q <= ev_q && (delta == 2'd2);
        end
    end

`ifdef DECODIFICADOR_X4_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            up   <= 1'b0;
            down <= 1'b0;
            err  <= 1'b0;
            dir  <= 1'b0;
        end else begin
            up   <= 1'b0;
            down <= 1'b0;
            err  <= 1'b0;
            if (enable) begin
                if (jump_q) begin
                    err <= 1'b1;
                end else if (cw_q) begin
                    up  <= 1'b1;
                    dir <= 1'b1;
                end else if (ccw_q) begin
                    down <= 1'b1;
                    dir  <= 1'b0;
                end
            end
        end
    end
`else
    localparam logic signed [2:0] AccMax = 3'sd3;
    localparam logic signed [2:0] AccMin = -3'sd3;

    logic signed [2:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            up    <= 1'b0;
            down  <= 1'b0;
            err   <= 1'b0;
            dir   <= 1'b0;
            acc_q <= '0;
        end else begin
            up   <= 1'b0;
            down <= 1'b0;
            err  <= 1'b0;
            if (!enable) begin
                acc_q <= '0;
            end else if (jump_q) begin
                err   <= 1'b1;
                acc_q <= '0;
            end else if (cw_q) begin
                dir <= 1'b1;
                if (acc_q == AccMax) begin
                    up    <= 1'b1;
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_q + 3'sd1;
                end
            end else if (ccw_q) begin
                dir <= 1'b0;
                if (acc_q == AccMin) begin
                    down  <= 1'b1;
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_q - 3'sd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_decodificador_cuadratura.sv
// Self-checking bench for decodificador_cuadratura: directed scenarios plus random walk
// checked every cycle against a position-based behavioural model.
module tb_decodificador_cuadratura;

    localparam int D = 4;
`ifdef DECODIFICADOR_X4_EN
    localparam int X4 = 1;
`else
    localparam int X4 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic a = 1'b0;
    logic b = 1'b0;
    logic up, down, err, dir;

    always #5 clk = ~clk;

    decodificador_cuadratura #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .a     (a),
        .b     (b),
        .up    (up),
        .down  (down),
        .err   (err),
        .dir   (dir)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit started = 0;

    // Position of each ab value on the CW circle and the inverse.
    int pos_of [4] = '{0, 1, 3, 2};
    logic [1:0] ab_of [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    typedef struct {
        int due;
        int delta;
    } ev_t;
    ev_t pend[$];

    logic [1:0] sh1, sh2, m_filt;
    int m_run, m_init_run, m_acc;
    bit m_track;
    logic m_up, m_down, m_err, m_dir;

    always @(posedge clk) begin
        logic [1:0] s_old, old;
        bit was_track, acc_now;
        ev_t e;
        cyc++;
        started = 1;
        m_up = 0;
        m_down = 0;
        m_err = 0;
        if (rst) begin
            sh1 = 0; sh2 = 0; m_filt = 0;
            m_run = 0; m_init_run = 0; m_acc = 0;
            m_track = 0; m_dir = 0;
            pend.delete();
        end else begin
            while (pend.size() > 0 && pend[0].due == cyc) begin
                e = pend.pop_front();
                if (enable) begin
                    if (e.delta == 2) begin
                        m_err = 1; m_acc = 0;
                    end else if (e.delta == 1) begin
                        m_dir = 1;
                        m_acc = m_acc + 1;
                        if (X4 == 1 || m_acc == 4) begin m_up = 1; m_acc = 0; end
                    end else if (e.delta == 3) begin
                        m_dir = 0;
                        m_acc = m_acc - 1;
                        if (X4 == 1 || m_acc == -4) begin m_down = 1; m_acc = 0; end
                    end
                end
            end
            if (!enable) m_acc = 0;
            s_old = sh2;
            sh2 = sh1;
            sh1 = {a, b};
            was_track = m_track;
            acc_now = 0;
            if (s_old != m_filt) begin
                m_run++;
                if (m_run == D) begin
                    acc_now = 1;
                    old = m_filt;
                    m_filt = s_old;
                    m_run = 0;
                    if (was_track) pend.push_back('{cyc + 2, (pos_of[s_old] - pos_of[old] + 4) % 4});
                    else m_track = 1;
                end
            end else begin
                m_run = 0;
            end
            if (!was_track && !acc_now) begin
                if (s_old == 2'b00) begin
                    m_init_run++;
                    if (m_init_run == D) m_track = 1;
                end else begin
                    m_init_run = 0;
                end
            end
        end
    end

    int n_up = 0, n_down = 0, n_err = 0, last_up_cyc = 0;

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if ({up, down, err, dir} !== {m_up, m_down, m_err, m_dir}) begin
                failures++;
                $display("FAIL outputs cyc=%0d got up/down/err/dir=%b%b%b%b required=%b%b%b%b",
                         cyc, up, down, err, dir, m_up, m_down, m_err, m_dir);
            end
            if (up === 1'b1) begin n_up++; last_up_cyc = cyc; end
            if (down === 1'b1) n_down++;
            if (err === 1'b1) n_err++;
        end
    end

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic set_ab(input logic [1:0] v, input int n);
        {a, b} = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_counts();
        n_up = 0; n_down = 0; n_err = 0;
    endtask

    int e0;
    int cur_pos;
    int r;

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        set_ab(2'b00, 20);
        check_eq("reset_up", n_up, 0);
        check_eq("reset_down", n_down, 0);
        check_eq("reset_err", n_err, 0);
        check_eq("reset_dir", int'(dir), 0);

        // Full CW detent with latency measurement on the final edge
        clr_counts();
        set_ab(2'b01, 8); set_ab(2'b11, 8); set_ab(2'b10, 8);
        e0 = cyc + 1;
        set_ab(2'b00, 12);
        check_eq("cw_up_count", n_up, X4 ? 4 : 1);
        check_eq("cw_latency", last_up_cyc - e0, 7);
        check_eq("cw_down_err", n_down + n_err, 0);
        check_eq("cw_dir", int'(dir), 1);

        // Full CCW detent
        clr_counts();
        set_ab(2'b10, 8); set_ab(2'b11, 8); set_ab(2'b01, 8); set_ab(2'b00, 12);
        check_eq("ccw_down_count", n_down, X4 ? 4 : 1);
        check_eq("ccw_up_err", n_up + n_err, 0);
        check_eq("ccw_dir", int'(dir), 0);

        // Three CW steps then three CCW steps
        clr_counts();
        set_ab(2'b01, 8); set_ab(2'b11, 8); set_ab(2'b10, 8);
        set_ab(2'b11, 8); set_ab(2'b01, 8); set_ab(2'b00, 12);
        check_eq("rev_up", n_up, X4 ? 3 : 0);
        check_eq("rev_down", n_down, X4 ? 3 : 0);

        // Glitches of 2 and 3 clk on a
        clr_counts();
        set_ab(2'b10, 2); set_ab(2'b00, 10);
        set_ab(2'b10, 3); set_ab(2'b00, 10);
        check_eq("glitch_strobes", n_up + n_down + n_err, 0);

        // Illegal jump then a full CW detent starting from 11
        clr_counts();
        set_ab(2'b11, 12);
        check_eq("jump_err", n_err, 1);
        check_eq("jump_updown", n_up + n_down, 0);
        set_ab(2'b10, 8); set_ab(2'b00, 8); set_ab(2'b01, 12);
        check_eq("after_jump_3", n_up, X4 ? 3 : 0);
        set_ab(2'b11, 12);
        check_eq("after_jump_4", n_up, X4 ? 4 : 1);

        // Disabled: full CW detent produces nothing
        clr_counts();
        enable = 0;
        set_ab(2'b10, 8); set_ab(2'b00, 8); set_ab(2'b01, 8); set_ab(2'b11, 12);
        check_eq("disabled_strobes", n_up + n_down + n_err, 0);
        enable = 1;
        set_ab(2'b11, 4);

        // Reset after two CW steps discards the partial count
        set_ab(2'b10, 8); set_ab(2'b00, 8);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        set_ab(2'b00, 10);
        clr_counts();
        set_ab(2'b01, 8); set_ab(2'b11, 12);
        check_eq("rst_partial_up", n_up, X4 ? 2 : 0);

        // Random walk with glitches, jumps, enable toggles and resets
        cur_pos = 2;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst = 1;
                repeat (2) @(negedge clk);
                rst = 0;
            end else if (r < 10) begin
                enable = ~enable;
                set_ab(ab_of[cur_pos], $urandom_range(1, 4));
            end else if (r < 15) begin
                cur_pos = (cur_pos + 2) % 4;
                set_ab(ab_of[cur_pos], $urandom_range(5, 10));
            end else if (r < 25) begin
                set_ab(ab_of[cur_pos] ^ 2'($urandom_range(1, 3)), $urandom_range(1, 3));
                set_ab(ab_of[cur_pos], 6);
            end else begin
                cur_pos = ($urandom_range(0, 1) == 1) ? (cur_pos + 1) % 4 : (cur_pos + 3) % 4;
                set_ab(ab_of[cur_pos], $urandom_range(3, 12));
            end
        end
        set_ab(ab_of[cur_pos], 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
